// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared encodings for the RV32 pipeline: writeback result select,
//            load funct3 codes and register-file address width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101
  } load_type_t;

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// Module   : load_extend
// Brief    : Combinational lane select and sign/zero extension of load data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extend
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [1:0]       i_off,
  input  logic [2:0]       i_load_type,
  output logic [WIDTH-1:0] o_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_off)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  // Halfword lane comes from off[1] only; misaligned halfwords trap upstream.
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_ext = i_word;
    case (i_load_type)
      LT_LB:   o_ext = {{(WIDTH-8){w_byte[7]}}, w_byte};
      LT_LBU:  o_ext = {{(WIDTH-8){1'b0}}, w_byte};
      LT_LH:   o_ext = {{(WIDTH-16){w_half[15]}}, w_half};
      LT_LHU:  o_ext = {{(WIDTH-16){1'b0}}, w_half};
      default: o_ext = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// Module   : writeback_stage
// Brief    : MEM/WB pipeline register with stall/flush, load extension and
//            writeback result select. Optional macro WB_RETIRE_CNT_EN adds a
//            retired-instruction counter output RetireCount.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidM,
  input  logic [WIDTH-1:0]      ALUResultM,
  input  logic [WIDTH-1:0]      ReadDataM,
  input  logic [WIDTH-1:0]      PCPlus4M,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            LoadTypeM,
  input  logic                  StallW,
  input  logic                  FlushW,
  output logic [WIDTH-1:0]      ResultW,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic                  RegWriteW,
  output logic                  ValidW
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [WIDTH-1:0]      RetireCount
`endif
);

  import riscv_pkg::*;

  logic                  r_valid;
  logic                  r_regwrite;
  logic [WIDTH-1:0]      r_alu;
  logic [WIDTH-1:0]      r_rdata;
  logic [WIDTH-1:0]      r_pc4;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [1:0]            r_result_src;
  logic [2:0]            r_load_type;
  logic [WIDTH-1:0]      w_load;
  logic [WIDTH-1:0]      w_result;

  // Flush only kills valid/regwrite; the data fields hold since they are dead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_alu        <= '0;
      r_rdata      <= '0;
      r_pc4        <= '0;
      r_rd         <= '0;
      r_result_src <= '0;
      r_load_type  <= '0;
    end else if (FlushW) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
    end else if (!StallW) begin
      r_valid      <= ValidM;
      r_regwrite   <= RegWriteM;
      r_alu        <= ALUResultM;
      r_rdata      <= ReadDataM;
      r_pc4        <= PCPlus4M;
      r_rd         <= RdM;
      r_result_src <= ResultSrcM;
      r_load_type  <= LoadTypeM;
    end
  end

  load_extend #(
    .WIDTH(WIDTH)
  ) u_load_extend (
    .i_word      (r_rdata),
    .i_off       (r_alu[1:0]),
    .i_load_type (r_load_type),
    .o_ext       (w_load)
  );

  always_comb begin
    w_result = r_alu;
    case (r_result_src)
      RES_MEM: w_result = w_load;
      RES_PC4: w_result = r_pc4;
      default: w_result = r_alu;
    endcase
  end

  assign ResultW   = w_result;
  assign RdW       = r_rd;
  assign ValidW    = r_valid;
  assign RegWriteW = r_regwrite & r_valid & (r_rd != '0);

`ifdef WB_RETIRE_CNT_EN
  logic [WIDTH-1:0] r_retire_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (ValidM && !FlushW && !StallW) begin
      r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  assign RetireCount = r_retire_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Pipeline stage directly downstream of the Memory stage in the pipelined RV32 core.
- Contains the MEM/WB pipeline register with stall and flush, and the valid bit.
- Extracts and extends load data (LB/LH/LW/LBU/LHU) using the byte offset.
- Selects the writeback result and drives the register-file write port and the forwarding path.

Parameters:
- WIDTH, 32, datapath width.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ValidM  in  1  instruction in M is real (not a bubble)
- ALUResultM  in  WIDTH  ALU result / memory address from M
- ReadDataM  in  WIDTH  word read from datamem in M
- PCPlus4M  in  WIDTH  PC+4 for JAL/JALR link
- RdM  in  REG_ADDR_W  destination register
- RegWriteM  in  1  register write enable
- ResultSrcM  in  2  00 ALU, 01 memory, 10 PC+4, 11 reserved
- LoadTypeM  in  3  funct3 of the load
- StallW  in  1  hold the MEM/WB register
- FlushW  in  1  replace the MEM/WB contents with a bubble
- ResultW  out  WIDTH  writeback data (also the forwarding source)
- RdW  out  REG_ADDR_W  writeback destination
- RegWriteW  out  1  qualified register-file write enable
- ValidW  out  1  W holds a real instruction

Behaviour:
- Clock, reset and register priority:
  - One clock (clk). rst is asynchronous and active-high.
  - Register update on the rising edge of clk, priority rst > FlushW > StallW > load.
  - rst (asynchronous, any time): all registered fields clear to 0. This gives ValidW=0, RegWriteW=0, RdW=0, ResultW=0.
  - FlushW=1: ValidW<=0 and RegWrite<=0. Other fields may be loaded or kept; they are don't-care but must not reach RegWriteW. FlushW wins over a simultaneous StallW.
  - StallW=1 (no flush): all fields hold. Outputs stay stable, and a valid write repeats each held cycle (idempotent).
  - Otherwise the register loads all M-side inputs.
- Latency: 1 cycle from M inputs to W outputs. Everything after the register is combinational.
- RegWriteW = RegWrite_reg & ValidW & (RdW != 0). Writes to x0 are suppressed.
- Load extraction, using registered offset off = ALUResult_reg[1:0]:
  - LB (000): byte at lane off, sign-extended.
  - LBU (100): byte at lane off, zero-extended.
  - LH (001): halfword at lane off[1] (bits 15:0 or 31:16), sign-extended. off[0] is ignored, since misalignment is trapped elsewhere.
  - LHU (101): same lane selection as LH, zero-extended.
  - LW (010) and all other encodings: full word, offset ignored.
- Result mux: 00 gives ALUResult_reg; 01 gives the extended load data; 10 gives PCPlus4_reg; 11 gives ALUResult_reg.
- When ValidW=0, ResultW still shows the mux output, but consumers must gate on RegWriteW.
- Reset mid-stall or mid-flush: reset dominates. The first post-reset edge behaves per the inputs at that edge.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- When defined, adds output RetireCount (WIDTH).
- RetireCount is a counter, reset to 0 by rst, that increments on each rising edge where the register loads with ValidM=1, FlushW=0 and StallW=0.
- It wraps from 2^WIDTH-1 to 0, with no saturation.
- When undefined, the port and counter are absent and the module is otherwise identical.

Decomposition:
- Shared package riscv_pkg holds:
  - result_src_t enum: RES_ALU, RES_MEM, RES_PC4.
  - load_type_t enum of funct3 codes: LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU.
  - REG_ADDR_W constant.
- One natural sub-module: load_extend (combinational, inputs word, off, load_type; output extended value), reusable by a future misalignment checker.

Test Plan:
- Assert rst mid-cycle with ValidM=1, RegWriteM=1 -> ValidW=0, RegWriteW=0, ResultW=0 immediately, without waiting for a clock edge.
- ReadDataM=0x8899AABB, ResultSrcM=01, ALUResultM low bits 01, LB -> ResultW=0xFFFFFFAA next cycle; LBU -> 0x000000AA; LH with off=10 -> 0xFFFF8899; LHU -> 0x00008899; LW -> 0x8899AABB.
- ResultSrcM=10, PCPlus4M=0x00000104, RdM=1, RegWriteM=1 -> ResultW=0x104, RegWriteW=1; same with RdM=0 -> RegWriteW=0.
- StallW=1 for 3 cycles while M inputs change -> W outputs frozen at the pre-stall values; on release, the new M values appear one cycle later.
- StallW=1 and FlushW=1 together with a valid write in M -> next cycle ValidW=0 and RegWriteW=0.
- With WB_RETIRE_CNT_EN: 5 valid loads, 1 stalled cycle and 1 flushed cycle -> RetireCount=5. Preload near 2^WIDTH-1 (force), one more valid load -> wraps to 0.
